lsu: RTL and testbench

- Load/store unit for the pipelined RISC-V core, MEM stage, directly upstream of the word-only data memory (1-cycle registered read, posedge write, no byte enables).
- Accepts one load/store per request from the pipeline and issues word-aligned accesses to the data memory.
- Performs read-modify-write for SB/SH and byte/halfword extraction with sign/zero extension for loads.
- Flags misaligned or illegal accesses.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and
// small helpers for legality, alignment and offset normalisation.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        RMW_WR  = 2'd2,
        ERR     = 2'd3
    } lsu_state_t;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic legal_load(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic legal_store(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

    // Drops the low address bits a halfword/word access cannot use, so an
    // unchecked misaligned access behaves as the aligned one below it.
    function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_W:        return 2'b00;
            F3_H, F3_HU: return {off[1], 1'b0};
            default:     return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extraction with extension,
// and store merge of a byte/halfword into an existing little-endian word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_f3,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [15:0] st_wdata,
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_f3,
    output logic [31:0] st_word
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = shifted[15:0];
        case (ld_f3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (st_f3)
            F3_B:    st_word[{st_off, 3'b000} +: 8]         = st_wdata[7:0];
            F3_H:    st_word[{st_off[1], 4'b0000} +: 16]    = st_wdata;
            default: st_word = st_old;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit in front of a word-only data memory with a
// 1-cycle registered read; sub-word stores are done as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output lsu_state_t  state_dbg
);

    lsu_state_t  state, state_nxt;
    logic [29:0] lat_wa;
    logic [1:0]  lat_off;
    logic [2:0]  lat_f3;
    logic [15:0] lat_wdata;
    logic        accept;
    logic        bad_req;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    // Handshake: a request transfers on a cycle where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and the requester holds
    // its fields stable until that cycle. rsp_valid/misalign_err are pulses
    // with no back-pressure.
    assign accept    = req_valid && req_ready;
    assign state_dbg = state;

    assign bad_req = (is_load && is_store)
                  || (is_load  && !legal_load(funct3))
                  || (is_store && !legal_store(funct3))
                  || (CHECK_ALIGN && (is_load || is_store) && misaligned(funct3, addr[1:0]));

    lsu_align u_align (
        .ld_word  (mem_rd),
        .ld_off   (lat_off),
        .ld_f3    (lat_f3),
        .ld_data  (ld_data),
        .st_old   (mem_rd),
        .st_wdata (lat_wdata),
        .st_off   (lat_off),
        .st_f3    (lat_f3),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_wa    <= '0;
            lat_off   <= '0;
            lat_f3    <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_wa    <= addr[31:2];
                lat_off   <= force_align(funct3, addr[1:0]);
                lat_f3    <= funct3;
                lat_wdata <= wdata[15:0];
            end
        end
    end

    // Outputs are gated by rst so an in-flight write or response dies the
    // moment reset asserts rather than at the next edge.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_a        = '0;
        mem_wd       = '0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        misalign_err = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    mem_a     = {addr[31:2], 2'b00};
                    if (req_valid && (is_load || is_store)) begin
                        if (bad_req) begin
                            state_nxt = ERR;
                        end else if (is_load) begin
                            mem_re    = 1'b1;
                            state_nxt = LD_WAIT;
                        end else if (funct3 == F3_W) begin
                            mem_we = 1'b1;
                            mem_wd = wdata;
                        end else begin
                            mem_re    = 1'b1;
                            state_nxt = RMW_WR;
                        end
                    end
                end
                LD_WAIT: begin
                    mem_a     = {lat_wa, 2'b00};
                    rsp_valid = 1'b1;
                    rsp_rdata = ld_data;
                    state_nxt = IDLE;
                end
                RMW_WR: begin
                    mem_a     = {lat_wa, 2'b00};
                    mem_we    = 1'b1;
                    mem_wd    = st_word;
                    state_nxt = IDLE;
                end
                ERR: begin
                    misalign_err = 1'b1;
                    state_nxt    = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: two instances (alignment checked / forced) on shared
// stimulus, each with its own word memory, and a response scoreboard.
module tb_lsu;
    import lsu_pkg::*;

    localparam int W = 49;  // {due_cycle[15:0], is_err, data[31:0]}

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        req_ready, rsp_valid, misalign_err, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
    lsu_state_t  state_dbg;

    logic        req_ready_a0, rsp_valid_a0, misalign_err_a0, mem_we_a0, mem_re_a0;
    logic [31:0] rsp_rdata_a0, mem_a_a0, mem_wd_a0, mem_rd_a0;
    lsu_state_t  state_dbg_a0;

    logic [31:0] dmem    [0:255];
    logic [31:0] dmem_a0 [0:255];

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic        acc_we, acc_re, stall_we;
    logic [31:0] acc_wd, acc_a, stall_wd, stall_a;
    int          last_acc, prev_acc;

    lsu #(.CHECK_ALIGN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misalign_err(misalign_err), .mem_we(mem_we), .mem_re(mem_re),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .state_dbg(state_dbg)
    );

    lsu #(.CHECK_ALIGN(1'b0)) u_dut_a0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a0),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rsp_valid(rsp_valid_a0), .rsp_rdata(rsp_rdata_a0),
        .misalign_err(misalign_err_a0), .mem_we(mem_we_a0), .mem_re(mem_re_a0),
        .mem_a(mem_a_a0), .mem_wd(mem_wd_a0), .mem_rd(mem_rd_a0), .state_dbg(state_dbg_a0)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required end", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- data memories ----------------
    always @(posedge clk) begin
        if (mem_re) mem_rd <= dmem[mem_a[9:2]];
        if (mem_we) dmem[mem_a[9:2]] <= mem_wd;
    end

    always @(posedge clk) begin
        if (mem_re_a0) mem_rd_a0 <= dmem_a0[mem_a_a0[9:2]];
        if (mem_we_a0) dmem_a0[mem_a_a0[9:2]] <= mem_wd_a0;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [15:0]  c16;
        if (rst) begin
            c16 = cyc[15:0];
            if (!rsp_valid) check("rdata_idle_zero", rsp_rdata, 32'h0);
            if (rsp_valid || misalign_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'({rsp_valid, misalign_err}), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 32'(c16), 32'(e[48:33]));
                    check("rsp_err", 32'(misalign_err), 32'(e[32]));
                    check("rsp_valid", 32'(rsp_valid), 32'(!e[32]));
                    check("rsp_rdata", rsp_rdata, e[32] ? 32'h0 : e[31:0]);
                    if (misalign_err) check("err_mem_quiet", 32'({mem_we, mem_re}), 32'h0);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // kind: 0 = no response expected, 1 = load data, 2 = misalign_err
    task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int kind, input logic [31:0] exp);
        int n;
        logic [15:0] c16;
        req_valid = 1'b1;
        is_load   = ld;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        n = 0;
        #1;
        while (!req_ready && n < 20) begin
            stall_we = mem_we;
            stall_wd = mem_wd;
            stall_a  = mem_a;
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            check("accept_timeout", 32'(n), 32'h0);
            return;
        end
        acc_we = mem_we;
        acc_re = mem_re;
        acc_wd = mem_wd;
        acc_a  = mem_a;
        @(posedge clk);
        #1;
        prev_acc = last_acc;
        last_acc = cyc;
        c16 = cyc[15:0];
        if (kind == 1) exp_q.push_back({c16, 1'b0, exp});
        else if (kind == 2) exp_q.push_back({c16, 1'b1, 32'h0});
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = F3_W; addr = 32'h100; wdata = 32'h0;
        stall_we = 1'b0; stall_wd = '0; stall_a = '0;
        last_acc = 0; prev_acc = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'h1);
        @(negedge clk);

        send(1'b0, 1'b1, F3_W, 32'h100, 32'hA1B2C3D4, 0, 32'h0);
        check("sw_we", 32'(acc_we), 32'h1);
        check("sw_re", 32'(acc_re), 32'h0);
        check("sw_wd", acc_wd, 32'hA1B2C3D4);
        check("sw_a", acc_a, 32'h100);
        send(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1, 32'hA1B2C3D4);
        check("lw_after_sw_gap", 32'(last_acc - prev_acc), 32'h1);
        check("lw_re", 32'(acc_re), 32'h1);

        send(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 2, 32'h0);
        check("lw_mis_re", 32'(acc_re), 32'h0);
        check("lw_mis_we", 32'(acc_we), 32'h0);
        check("noalign_lw_valid", 32'(rsp_valid_a0), 32'h1);
        check("noalign_lw_data", rsp_rdata_a0, 32'hA1B2C3D4);

        send(1'b1, 1'b0, F3_B,  32'h103, 32'h0, 1, 32'hFFFFFFA1);
        send(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 1, 32'h000000A1);
        send(1'b1, 1'b0, F3_H,  32'h102, 32'h0, 1, 32'hFFFFA1B2);
        send(1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 1, 32'h0000C3D4);

        send(1'b0, 1'b1, F3_B, 32'h101, 32'h000000EE, 0, 32'h0);
        check("sb_re", 32'(acc_re), 32'h1);
        check("sb_we_accept", 32'(acc_we), 32'h0);
        send(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1, 32'hA1B2EED4);
        check("sb_stall_len", 32'(last_acc - prev_acc), 32'h2);
        check("rmw_we", 32'(stall_we), 32'h1);
        check("rmw_wd", stall_wd, 32'hA1B2EED4);
        check("rmw_a", stall_a, 32'h100);

        send(1'b0, 1'b1, F3_H, 32'h102, 32'h00005566, 0, 32'h0);
        send(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1, 32'h5566EED4);

        send(1'b0, 1'b1, F3_H, 32'h101, 32'h0000BEEF, 2, 32'h0);
        check("sh_mis_re", 32'(acc_re), 32'h0);
        check("sh_mis_we", 32'(acc_we), 32'h0);
        send(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 2, 32'h0);
        send(1'b1, 1'b1, F3_W, 32'h100, 32'h0, 2, 32'h0);
        send(1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 2, 32'h0);
        check("illegal_st_we", 32'(acc_we), 32'h0);

        send(1'b0, 1'b0, F3_W, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        check("noop_mem", 32'({acc_we, acc_re}), 32'h0);
        idle(2);

        send(1'b0, 1'b1, F3_B, 32'h100, 32'h00000077, 0, 32'h0);
        check("rmw_we_pre_rst", 32'(mem_we), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_drops_we", 32'(mem_we), 32'h0);
        check("rst_ready_low", 32'(req_ready), 32'h0);
        idle(2);
        rst = 1'b1;
        #1;
        check("ready_after_rst2", 32'(req_ready), 32'h1);
        send(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1, 32'h5566EED4);

        send(1'b0, 1'b1, F3_B, 32'h100, 32'h00000011, 0, 32'h0);
        send(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 1, 32'h5566EE11);
        check("b2b_accept_gap", 32'(last_acc - prev_acc), 32'h2);

        idle(4);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
